// File: rtl/sync_pulse_rx.sv
// sync_pulse_rx: four-phase req/ack receiver that turns each source handshake into one valid/ready transfer; define SYNC_PULSE_RX_ERR_EN to add err_clr/proto_err protocol checking
module sync_pulse_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_async,
  output logic             ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] evt_cnt
`ifdef SYNC_PULSE_RX_ERR_EN
  ,
  input  logic             err_clr,
  output logic             proto_err
`endif
);
  // Encoding chosen so out_valid and ack come straight off state flops.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EMIT = 2'b01;
  localparam logic [1:0] ACK  = 2'b10;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_req;
  logic                   w_accept;
  logic                   w_viol;
  logic [1:0]             w_next;
  assign w_req    = r_sync[SYNC_STAGES-1];
  assign w_accept = (r_state == EMIT) && out_ready;
`ifdef SYNC_PULSE_RX_ERR_EN
  assign w_viol   = (r_state == EMIT) && !out_ready && !w_req;
`else
  assign w_viol   = 1'b0;
`endif
  assign w_next = (r_state == IDLE) ? (w_req ? EMIT : IDLE) :
                  (r_state == EMIT) ? (w_accept ? ACK : (w_viol ? IDLE : EMIT)) :
                  (w_req ? ACK : IDLE);
  assign out_valid = r_state[0];
  assign ack       = r_state[1];
  assign evt_cnt   = r_cnt;
  // Synchronizer chain: the only logic that touches req_async.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], req_async};
  end
  // Handshake FSM: IDLE -> EMIT on request, EMIT -> ACK on transfer, ACK -> IDLE on request release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Event counter bumps once per accepted transfer and wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
  end
`ifdef SYNC_PULSE_RX_ERR_EN
  logic r_err;
  assign proto_err = r_err;
  // Sticky violation flag; a new violation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_viol | (r_err & ~err_clr);
  end
`endif
endmodule

// File: tb/tb_sync_pulse_rx.sv
// tb_sync_pulse_rx: directed self-checking bench for sync_pulse_rx
module tb_sync_pulse_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_async = 1'b0;
  logic       out_ready = 1'b0;
  logic       ack;
  logic       out_valid;
  logic [7:0] evt_cnt;
  int         checks = 0;
  int         errors = 0;
  int         rises = 0;
  logic       prev_ov = 1'b0;
`ifdef SYNC_PULSE_RX_ERR_EN
  logic err_clr = 1'b0;
  logic proto_err;
`endif

  sync_pulse_rx #(.SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_async(req_async), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .evt_cnt(evt_cnt)
`ifdef SYNC_PULSE_RX_ERR_EN
    , .err_clr(err_clr), .proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid && !prev_ov) rises++;
    prev_ov = out_valid;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_async = 1'b0;
    out_ready = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_ack(input logic val, input string name);
    int n = 0;
    while (ack !== val && n < 20) begin
      tick(1);
      n++;
    end
    checks++; if (ack !== val) begin errors++; $display("FAIL %s ack got %b want %b (timeout)", name, ack, val); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov got %b want 0", out_valid); end
    checks++; if (evt_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", evt_cnt); end
`ifdef SYNC_PULSE_RX_ERR_EN
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", proto_err); end
`endif
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    int r0;
    do_reset();
    r0 = rises;
    out_ready = 1'b1;
    req_async = 1'b1;
    tick(2);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_ov got %b want 0", out_valid); end
    tick(1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_ov_rise got %b want 1", out_valid); end
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_emit got %b want 0", ack); end
    tick(1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_ov_fall got %b want 0", out_valid); end
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack_rise got %b want 1", ack); end
    checks++; if (evt_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt got %0d want 1", evt_cnt); end
    tick(6);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack_hold got %b want 1", ack); end
    req_async = 1'b0;
    tick(2);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL basic_ack_pre_drop got %b want 1", ack); end
    tick(1);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL basic_ack_drop got %b want 0", ack); end
    tick(4);
    checks++; if (rises - r0 !== 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", rises - r0); end
    checks++; if (evt_cnt !== 8'd1) begin errors++; $display("FAIL basic_cnt_end got %0d want 1", evt_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_async = 1'b1;
    tick(3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_ov_rise got %b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++; if (out_valid !== 1'b1 || ack !== 1'b0 || evt_cnt !== 8'd0) begin errors++; $display("FAIL bp_hold%0d ov %b ack %b cnt %0d want 1 0 0", i, out_valid, ack, evt_cnt); end
    end
    out_ready = 1'b1;
    tick(1);
    checks++; if (out_valid !== 1'b0 || ack !== 1'b1 || evt_cnt !== 8'd1) begin errors++; $display("FAIL bp_accept ov %b ack %b cnt %0d want 0 1 1", out_valid, ack, evt_cnt); end
    req_async = 1'b0;
    wait_ack(1'b0, "bp_release");
  endtask

  task automatic test_wrap();
    int r0;
    do_reset();
    out_ready = 1'b1;
    r0 = rises;
    for (int i = 0; i < 256; i++) begin
      req_async = 1'b1;
      wait_ack(1'b1, "wrap_ack_hi");
      if (i == 254) begin
        checks++; if (evt_cnt !== 8'd255) begin errors++; $display("FAIL wrap_cnt255 got %0d want 255", evt_cnt); end
      end
      req_async = 1'b0;
      wait_ack(1'b0, "wrap_ack_lo");
    end
    tick(2);
    checks++; if (evt_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt got %0d want 0", evt_cnt); end
    checks++; if (rises - r0 !== 256) begin errors++; $display("FAIL wrap_pulses got %0d want 256", rises - r0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    req_async = 1'b1;
    tick(4);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rmid_in_ack got %b want 1", ack); end
    rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0 || out_valid !== 1'b0 || evt_cnt !== 8'd0) begin errors++; $display("FAIL rmid_async ack %b ov %b cnt %0d want 0 0 0", ack, out_valid, evt_cnt); end
    #1;
    rst_n = 1'b1;
    tick(3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_redeliver got %b want 1", out_valid); end
    tick(1);
    checks++; if (ack !== 1'b1 || evt_cnt !== 8'd1) begin errors++; $display("FAIL rmid_accept ack %b cnt %0d want 1 1", ack, evt_cnt); end
    req_async = 1'b0;
    wait_ack(1'b0, "rmid_release");
  endtask

  task automatic test_proto();
    do_reset();
    req_async = 1'b1;
    tick(3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL proto_ov_rise got %b want 1", out_valid); end
    req_async = 1'b0;
    tick(2);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL proto_ov_still got %b want 1", out_valid); end
    tick(1);
`ifdef SYNC_PULSE_RX_ERR_EN
    checks++; if (proto_err !== 1'b1 || out_valid !== 1'b0 || evt_cnt !== 8'd0) begin errors++; $display("FAIL proto_viol err %b ov %b cnt %0d want 1 0 0", proto_err, out_valid, evt_cnt); end
    tick(2);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", proto_err); end
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clr got %b want 0", proto_err); end
`else
    checks++; if (out_valid !== 1'b1 || evt_cnt !== 8'd0) begin errors++; $display("FAIL proto_ignore ov %b cnt %0d want 1 0", out_valid, evt_cnt); end
    out_ready = 1'b1;
    tick(1);
    checks++; if (out_valid !== 1'b0 || ack !== 1'b1 || evt_cnt !== 8'd1) begin errors++; $display("FAIL proto_deliver ov %b ack %b cnt %0d want 0 1 1", out_valid, ack, evt_cnt); end
    tick(1);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL proto_ack_exit got %b want 0", ack); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_proto();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
